// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: writeback/CSR/fetch-facing signals of trap_sequencer.
// The surrounding pipeline drives through the master modport, the
// sequencer itself connects through the slave modport.
interface trap_sequencer_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_exception;
  logic [3:0]  wb_exc_cause;
  logic        wb_mret;
  logic        eip;
  logic        tip;
  logic        sip;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;
  logic        fetch_ready;
  logic        retired;
  logic        traped;
  logic        interupt;
  logic [3:0]  trap_cause;
  logic [31:0] ecp;
  logic        mret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output wb_valid, wb_pc, wb_exception, wb_exc_cause, wb_mret,
    output eip, tip, sip, trap_vector, mret_vector, fetch_ready,
    input  retired, traped, interupt, trap_cause, ecp, mret,
    input  flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  wb_valid, wb_pc, wb_exception, wb_exc_cause, wb_mret,
    input  eip, tip, sip, trap_vector, mret_vector, fetch_ready,
    output retired, traped, interupt, trap_cause, ecp, mret,
    output flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: selects trap/mret events at writeback, strobes the CSR
// file, flushes the pipeline for FLUSH_CYCLES cycles and hands the new PC
// to fetch over a valid/ready handshake.
// Optional feature: define TRAP_SEQ_VECTORED_EN for vectored interrupt
// targets (mtvec[0]=1 -> base + 4*cause for interrupts).
module trap_sequencer #(
  parameter int FLUSH_CYCLES = 3
) (
  input logic              clk,
  input logic              reset,
  trap_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic        sel_mret;
  logic        trap_evt;
  logic        ret_evt;
  logic        evt_irq;
  logic [3:0]  evt_cause;
  logic [31:0] trap_base;
  logic [31:0] trap_tgt;
  logic        unused_tvec_bits;

  // mtvec mode bits only matter for the vectored build
  assign unused_tvec_bits = ^bus.trap_vector[1:0];

  // Event selection in IDLE: exception beats interrupts (E, S, T), mret last
  always_comb begin
    trap_evt  = 1'b0;
    ret_evt   = 1'b0;
    evt_irq   = 1'b0;
    evt_cause = 4'd0;
    if (state == IDLE && bus.wb_valid && !reset) begin
      if (bus.wb_exception) begin
        trap_evt  = 1'b1;
        evt_cause = bus.wb_exc_cause;
      end else if (bus.eip) begin
        trap_evt  = 1'b1;
        evt_irq   = 1'b1;
        evt_cause = 4'd11;
      end else if (bus.sip) begin
        trap_evt  = 1'b1;
        evt_irq   = 1'b1;
        evt_cause = 4'd3;
      end else if (bus.tip) begin
        trap_evt  = 1'b1;
        evt_irq   = 1'b1;
        evt_cause = 4'd7;
      end else if (bus.wb_mret) begin
        ret_evt   = 1'b1;
      end
    end
  end

  // A trapping instruction does not commit; mret and ordinary ones do
  assign bus.retired = (state == IDLE) && bus.wb_valid && !reset && !trap_evt;

  // Trap target from the live mtvec, so a CSR write during the drain is seen
  always_comb begin
    trap_base = {bus.trap_vector[31:2], 2'b00};
    trap_tgt  = trap_base;
`ifdef TRAP_SEQ_VECTORED_EN
    if (bus.trap_vector[0] && bus.interupt)
      trap_tgt = trap_base + {26'd0, bus.trap_cause, 2'b00};
`endif
  end

  // Sequencer FSM: IDLE -> FLUSH (drain) -> REDIRECT (wait for fetch)
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      flush_cnt          <= 4'd0;
      sel_mret           <= 1'b0;
      bus.traped         <= 1'b0;
      bus.mret           <= 1'b0;
      bus.interupt       <= 1'b0;
      bus.trap_cause     <= 4'd0;
      bus.ecp            <= 32'd0;
      bus.flush          <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= 32'd0;
    end else begin
      bus.traped <= 1'b0;
      bus.mret   <= 1'b0;
      case (state)
        IDLE: begin
          if (trap_evt) begin
            bus.traped     <= 1'b1;
            bus.interupt   <= evt_irq;
            bus.trap_cause <= evt_cause;
            bus.ecp        <= bus.wb_pc;
            sel_mret       <= 1'b0;
            bus.flush      <= 1'b1;
            flush_cnt      <= CNT_INIT;
            state          <= FLUSH;
          end else if (ret_evt) begin
            bus.mret       <= 1'b1;
            sel_mret       <= 1'b1;
            bus.flush      <= 1'b1;
            flush_cnt      <= CNT_INIT;
            state          <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= sel_mret ? bus.mret_vector : trap_tgt;
            state              <= REDIRECT;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (bus.fetch_ready) begin
            bus.redirect_valid <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: directed vector table, hand-written stall
// and reset sequences, then randomized traffic against a reference model.
module tb_trap_sequencer;

  localparam int FC = 3;
`ifdef TRAP_SEQ_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  trap_sequencer_if bus();

  trap_sequencer #(.FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        exc;
    logic [3:0]  cause;
    logic        mr;
    logic        eip;
    logic        tip;
    logic        sip;
    logic [31:0] pc;
    logic [31:0] tv;
    logic [31:0] mv;
    logic        e_evt;
    logic        e_trap;
    logic        e_mret;
    logic        e_irq;
    logic [3:0]  e_cause;
    logic        e_ret;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Trap target as the architecture defines it
  function automatic logic [31:0] tgt(input logic [31:0] tv, input logic irq, input logic [3:0] cause);
    logic [31:0] b;
    b = tv & 32'hFFFF_FFFC;
    if (VEC && tv[0] && irq) b = b + 32'(cause) * 32'd4;
    return b;
  endfunction

  task automatic idle_inputs();
    bus.wb_valid     = 1'b0;
    bus.wb_exception = 1'b0;
    bus.wb_exc_cause = 4'd0;
    bus.wb_mret      = 1'b0;
    bus.eip          = 1'b0;
    bus.tip          = 1'b0;
    bus.sip          = 1'b0;
    bus.fetch_ready  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_ret(input logic exp_ret, input string name);
    @(negedge clk);
    chk(name, 32'(bus.retired), 32'(exp_ret));
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".traped"}, 32'(bus.traped), 32'd0);
    chk({tag, ".mret"}, 32'(bus.mret), 32'd0);
    chk({tag, ".interupt"}, 32'(bus.interupt), 32'd0);
    chk({tag, ".trap_cause"}, 32'(bus.trap_cause), 32'd0);
    chk({tag, ".ecp"}, bus.ecp, 32'd0);
    chk({tag, ".flush"}, 32'(bus.flush), 32'd0);
    chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
    chk({tag, ".redirect_pc"}, bus.redirect_pc, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model state: md = cycles since event (0 = idle)
  int          md;
  logic        m_sel_mret;
  logic        m_irq;
  logic [3:0]  m_cause;
  logic [31:0] m_ecp;
  logic [31:0] m_rpc;
  logic        e_trap;
  logic        e_mret;

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.wb_pc       = 32'd0;
    bus.trap_vector = 32'd0;
    bus.mret_vector = 32'd0;
    tick();
    tick();
    chk_zero("reset_state");
    reset = 1'b0;

    // ---------------- directed vector table ----------------
    //              valid exc cause  mr eip tip sip  pc            tv            mv             evt trap mret irq cause  ret rpc
    tbl[0]  = '{Y, Y, 4'd2,  N, N, N, N, 32'h100, 32'h80,   32'h0,   Y, Y, N, N, 4'd2,  N, 32'h80};
    tbl[1]  = '{Y, N, 4'd0,  N, Y, Y, Y, 32'h104, 32'h80,   32'h0,   Y, Y, N, Y, 4'd11, N, 32'h80};
    tbl[2]  = '{Y, N, 4'd0,  N, N, Y, Y, 32'h108, 32'h80,   32'h0,   Y, Y, N, Y, 4'd3,  N, 32'h80};
    tbl[3]  = '{Y, N, 4'd0,  N, N, Y, N, 32'h10C, 32'h80,   32'h0,   Y, Y, N, Y, 4'd7,  N, 32'h80};
    tbl[4]  = '{Y, N, 4'd0,  Y, N, N, N, 32'h110, 32'h80,   32'h204, Y, N, Y, N, 4'd0,  Y, 32'h204};
    tbl[5]  = '{Y, N, 4'd0,  N, N, Y, N, 32'h114, 32'h1001, 32'h0,   Y, Y, N, Y, 4'd7,  N,
                VEC ? 32'h101C : 32'h1000};
    tbl[6]  = '{Y, Y, 4'd5,  N, N, N, N, 32'h118, 32'h1001, 32'h0,   Y, Y, N, N, 4'd5,  N, 32'h1000};
    tbl[7]  = '{Y, Y, 4'd3,  Y, N, N, N, 32'h11C, 32'h400,  32'h204, Y, Y, N, N, 4'd3,  N, 32'h400};
    tbl[8]  = '{Y, N, 4'd0,  N, N, N, N, 32'h120, 32'h80,   32'h0,   N, N, N, N, 4'd0,  Y, 32'h0};
    tbl[9]  = '{N, N, 4'd0,  N, N, Y, N, 32'h124, 32'h80,   32'h0,   N, N, N, N, 4'd0,  N, 32'h0};
    tbl[10] = '{Y, Y, 4'hF,  N, Y, N, N, 32'h128, 32'h80,   32'h0,   Y, Y, N, N, 4'hF,  N, 32'h80};
    tbl[11] = '{Y, N, 4'd0,  N, Y, N, N, 32'h12C, 32'h1001, 32'h0,   Y, Y, N, Y, 4'd11, N,
                VEC ? 32'h102C : 32'h1000};

    for (int i = 0; i < 12; i++) begin
      bus.wb_valid     = tbl[i].valid;
      bus.wb_exception = tbl[i].exc;
      bus.wb_exc_cause = tbl[i].cause;
      bus.wb_mret      = tbl[i].mr;
      bus.eip          = tbl[i].eip;
      bus.tip          = tbl[i].tip;
      bus.sip          = tbl[i].sip;
      bus.wb_pc        = tbl[i].pc;
      bus.trap_vector  = tbl[i].tv;
      bus.mret_vector  = tbl[i].mv;
      bus.fetch_ready  = 1'b1;
      step_ret(tbl[i].e_ret, $sformatf("tbl%0d.retired", i));
      idle_inputs();
      chk($sformatf("tbl%0d.traped", i), 32'(bus.traped), 32'(tbl[i].e_trap));
      chk($sformatf("tbl%0d.mret", i), 32'(bus.mret), 32'(tbl[i].e_mret));
      if (tbl[i].e_trap) begin
        chk($sformatf("tbl%0d.interupt", i), 32'(bus.interupt), 32'(tbl[i].e_irq));
        chk($sformatf("tbl%0d.cause", i), 32'(bus.trap_cause), 32'(tbl[i].e_cause));
        chk($sformatf("tbl%0d.ecp", i), bus.ecp, tbl[i].pc);
      end
      chk($sformatf("tbl%0d.flush_t1", i), 32'(bus.flush), 32'(tbl[i].e_evt));
      chk($sformatf("tbl%0d.rv_t1", i), 32'(bus.redirect_valid), 32'd0);
      if (tbl[i].e_evt) begin
        for (int k = 2; k <= FC + 1; k++) begin
          tick();
          chk($sformatf("tbl%0d.traped_t%0d", i, k), 32'(bus.traped | bus.mret), 32'd0);
          chk($sformatf("tbl%0d.flush_t%0d", i, k), 32'(bus.flush), 32'(k <= FC));
          chk($sformatf("tbl%0d.rv_t%0d", i, k), 32'(bus.redirect_valid), 32'(k == FC + 1));
        end
        chk($sformatf("tbl%0d.redirect_pc", i), bus.redirect_pc, tbl[i].e_rpc);
        tick();
        chk($sformatf("tbl%0d.rv_drop", i), 32'(bus.redirect_valid), 32'd0);
      end
    end

    // ---------------- stall in REDIRECT, interrupts ignored ----------------
    bus.trap_vector  = 32'h80;
    bus.wb_valid     = 1'b1;
    bus.wb_exception = 1'b1;
    bus.wb_exc_cause = 4'd1;
    bus.wb_pc        = 32'h300;
    step_ret(1'b0, "stall.retired_evt");
    idle_inputs();
    bus.fetch_ready = 1'b0;
    for (int k = 0; k < FC; k++) tick();
    chk("stall.rv_rise", 32'(bus.redirect_valid), 32'd1);
    chk("stall.rpc", bus.redirect_pc, 32'h80);
    for (int k = 0; k < 5; k++) begin
      bus.wb_valid    = k[0];
      bus.tip         = 1'b1;
      bus.trap_vector = 32'h900;
      step_ret(1'b0, $sformatf("stall.retired%0d", k));
      chk($sformatf("stall.rv%0d", k), 32'(bus.redirect_valid), 32'd1);
      chk($sformatf("stall.rpc%0d", k), bus.redirect_pc, 32'h80);
      chk($sformatf("stall.traped%0d", k), 32'(bus.traped), 32'd0);
    end
    bus.fetch_ready = 1'b1;
    bus.wb_valid    = 1'b1;
    step_ret(1'b0, "stall.retired_accept");
    chk("stall.rv_drop", 32'(bus.redirect_valid), 32'd0);
    step_ret(1'b0, "stall.retired_pending");
    chk("stall.pending_traped", 32'(bus.traped), 32'd1);
    chk("stall.pending_cause", 32'(bus.trap_cause), 32'd7);
    chk("stall.pending_irq", 32'(bus.interupt), 32'd1);
    idle_inputs();
    for (int k = 0; k < FC + 2; k++) tick();

    // ---------------- reset mid-FLUSH ----------------
    bus.wb_valid     = 1'b1;
    bus.wb_exception = 1'b1;
    bus.wb_exc_cause = 4'd4;
    step_ret(1'b0, "rstf.retired_evt");
    idle_inputs();
    chk("rstf.flushing", 32'(bus.flush), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rstf");
    bus.wb_valid = 1'b1;
    step_ret(1'b1, "rstf.idle_retired");
    chk("rstf.no_trap", 32'(bus.traped), 32'd0);

    // ---------------- reset mid-REDIRECT ----------------
    bus.wb_exception = 1'b1;
    step_ret(1'b0, "rstr.retired_evt");
    idle_inputs();
    bus.fetch_ready = 1'b0;
    for (int k = 0; k < FC; k++) tick();
    chk("rstr.rv_before", 32'(bus.redirect_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rstr");
    bus.wb_valid = 1'b1;
    step_ret(1'b1, "rstr.idle_retired");

    // ---------------- reset suppresses a same-cycle event ----------------
    bus.wb_exception = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("rsts.traped", 32'(bus.traped), 32'd0);
    chk("rsts.flush", 32'(bus.flush), 32'd0);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    md         = 0;
    m_sel_mret = 1'b0;
    m_irq      = 1'b0;
    m_cause    = 4'd0;
    m_ecp      = 32'd0;
    m_rpc      = 32'd0;
    for (int c = 0; c < 600; c++) begin
      logic has_trap;
      logic exp_ret;
      bus.wb_valid     = ($urandom % 4) != 0;
      bus.wb_exception = ($urandom % 6) == 0;
      bus.wb_exc_cause = 4'($urandom);
      bus.wb_mret      = ($urandom % 4) == 0;
      bus.eip          = ($urandom % 9) == 0;
      bus.tip          = ($urandom % 9) == 0;
      bus.sip          = ($urandom % 9) == 0;
      bus.wb_pc        = $urandom;
      bus.trap_vector  = ($urandom & 32'h0000_FFFF);
      bus.mret_vector  = $urandom;
      bus.fetch_ready  = ($urandom % 3) != 0;
      reset            = ($urandom % 60) == 0;
      @(negedge clk);
      has_trap = bus.wb_exception | bus.eip | bus.sip | bus.tip;
      exp_ret  = (md == 0) && bus.wb_valid && !reset && !has_trap;
      chk($sformatf("rnd%0d.retired", c), 32'(bus.retired), 32'(exp_ret));
      e_trap = 1'b0;
      e_mret = 1'b0;
      if (reset) begin
        md = 0; m_rpc = 32'd0; m_ecp = 32'd0; m_irq = 1'b0; m_cause = 4'd0;
      end else if (md == 0) begin
        if (bus.wb_valid && has_trap) begin
          e_trap = 1'b1; md = 1; m_sel_mret = 1'b0; m_ecp = bus.wb_pc;
          if (bus.wb_exception) begin m_irq = 1'b0; m_cause = bus.wb_exc_cause; end
          else if (bus.eip)     begin m_irq = 1'b1; m_cause = 4'd11; end
          else if (bus.sip)     begin m_irq = 1'b1; m_cause = 4'd3; end
          else                  begin m_irq = 1'b1; m_cause = 4'd7; end
        end else if (bus.wb_valid && bus.wb_mret) begin
          e_mret = 1'b1; md = 1; m_sel_mret = 1'b1;
        end
      end else if (md <= FC) begin
        md++;
        if (md == FC + 1)
          m_rpc = m_sel_mret ? bus.mret_vector : tgt(bus.trap_vector, m_irq, m_cause);
      end else if (bus.fetch_ready) begin
        md = 0;
      end
      tick();
      chk($sformatf("rnd%0d.traped", c), 32'(bus.traped), 32'(e_trap));
      chk($sformatf("rnd%0d.mret", c), 32'(bus.mret), 32'(e_mret));
      chk($sformatf("rnd%0d.flush", c), 32'(bus.flush), 32'(md >= 1 && md <= FC));
      chk($sformatf("rnd%0d.rv", c), 32'(bus.redirect_valid), 32'(md > FC));
      chk($sformatf("rnd%0d.rpc", c), bus.redirect_pc, m_rpc);
      if (e_trap || reset) begin
        chk($sformatf("rnd%0d.irq", c), 32'(bus.interupt), 32'(m_irq));
        chk($sformatf("rnd%0d.cause", c), 32'(bus.trap_cause), 32'(m_cause));
        chk($sformatf("rnd%0d.ecp", c), bus.ecp, m_ecp);
      end
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
